// File: rtl/reg_share_arbiter.sv
// Round-robin arbiter that serialises writes from N requesters into one shared
// WIDTH-bit register, acknowledging each completed write with a one-cycle pulse.
`timescale 1ns/1ps

module reg_share_arbiter #(
  parameter int N     = 4,
  parameter int WIDTH = 8,
  parameter int IDW   = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N-1:0]       req,
  input  logic [N*WIDTH-1:0] wdata,
  output logic [N-1:0]       grant,
  output logic [N-1:0]       ack,
  output logic [WIDTH-1:0]   q,
  output logic [IDW-1:0]     last_id,
  output logic               busy
);

  typedef enum logic {IDLE, LOAD} state_t;

  state_t         state;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] gidx;
  logic [N-1:0]   ereq;
  logic [IDW-1:0] win;
  logic           found;
  int             idx;

  // A requester being acknowledged this cycle is masked so it cannot win twice in a row.
  assign ereq = req & ~ack;

  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!found && ereq[idx]) begin
        found = 1'b1;
        win   = IDW'(idx);
      end
    end
  end

  // Single FSM: IDLE picks a winner, LOAD commits its word and hands priority onward.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      ptr     <= '0;
      gidx    <= '0;
      grant   <= '0;
      ack     <= '0;
      q       <= '0;
      last_id <= '0;
      busy    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          ack <= '0;
          if (found) begin
            grant <= N'(1) << win;
            gidx  <= win;
            busy  <= 1'b1;
            state <= LOAD;
          end else begin
            grant <= '0;
          end
        end
        LOAD: begin
          q       <= wdata[int'(gidx)*WIDTH +: WIDTH];
          last_id <= gidx;
          ack     <= grant;
          grant   <= '0;
          busy    <= 1'b0;
          ptr     <= (gidx == IDW'(N-1)) ? '0 : gidx + 1'b1;
          state   <= IDLE;
        end
        default: begin
          state <= IDLE;
          grant <= '0;
          ack   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_share_arbiter.sv
// Self-checking bench for reg_share_arbiter: scenario tasks plus an ack scoreboard
// that pairs every acknowledge with the write expected when its request was driven.
`timescale 1ns/1ps

module tb_reg_share_arbiter;

  localparam int N     = 4;
  localparam int WIDTH = 8;
  localparam int IDW   = 2;

  typedef struct packed {
    logic [IDW-1:0]   id;
    logic [WIDTH-1:0] data;
  } exp_t;

  logic               clk;
  logic               reset;
  logic [N-1:0]       req;
  logic [N*WIDTH-1:0] wdata;
  logic [N-1:0]       grant;
  logic [N-1:0]       ack;
  logic [WIDTH-1:0]   q;
  logic [IDW-1:0]     last_id;
  logic               busy;

  int   checks = 0;
  int   fails  = 0;
  int   cycle  = 0;
  exp_t sb_q[$];

  reg_share_arbiter #(.N(N), .WIDTH(WIDTH), .IDW(IDW)) dut (
    .clk(clk), .reset(reset), .req(req), .wdata(wdata),
    .grant(grant), .ack(ack), .q(q), .last_id(last_id), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  // Every ack must match the oldest outstanding expected write; an ack with nothing pending is an error.
  always @(negedge clk) begin
    exp_t e;
    if (ack !== '0) begin
      checks++;
      if (sb_q.size() == 0) begin
        fails++;
        $display("[TB] FAIL sb_unexpected_ack: ack=%b q=%h, required no ack", ack, q);
      end else begin
        e = sb_q.pop_front();
        if (ack !== (N'(1) << e.id) || q !== e.data || last_id !== e.id) begin
          fails++;
          $display("[TB] FAIL sb_write: ack=%b q=%h last_id=%0d, required ack=%b q=%h last_id=%0d",
                   ack, q, last_id, N'(1) << e.id, e.data, e.id);
        end
      end
    end
  end

  task automatic pulse_reset();
    reset = 1'b1;
    req   = '0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic drain(input string name);
    for (int c = 0; c < 12 && sb_q.size() != 0; c++) @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      fails++;
      $display("[TB] FAIL %s_drain: %0d writes outstanding, required 0", name, sb_q.size());
      sb_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req   = 4'b1111;
    wdata = {8'h44, 8'h33, 8'h22, 8'h11};
    #2;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (grant !== '0 || ack !== '0 || q !== 8'h00 || busy !== 1'b0) begin
        fails++;
        $display("[TB] FAIL reset_hold: grant=%b ack=%b q=%h busy=%b, required all zero",
                 grant, ack, q, busy);
      end
    end
    reset = 1'b0;
    sb_q.push_back('{id: 2'd0, data: 8'h11});
    @(negedge clk);
    checks++;
    if (grant !== 4'b0001) begin
      fails++;
      $display("[TB] FAIL reset_first_grant: grant=%b, required 0001", grant);
    end
    req = '0;
    drain("reset");
  endtask

  task automatic test_single();
    pulse_reset();
    wdata[2*WIDTH +: WIDTH] = 8'hA5;
    req = 4'b0100;
    sb_q.push_back('{id: 2'd2, data: 8'hA5});
    @(negedge clk);
    checks++;
    if (grant !== 4'b0100 || busy !== 1'b1) begin
      fails++;
      $display("[TB] FAIL single_grant: grant=%b busy=%b, required 0100 1", grant, busy);
    end
    req = '0;
    @(negedge clk);
    checks++;
    if (q !== 8'hA5 || ack !== 4'b0100 || last_id !== 2'd2 || grant !== '0) begin
      fails++;
      $display("[TB] FAIL single_load: q=%h ack=%b last_id=%0d grant=%b, required a5 0100 2 0000",
               q, ack, last_id, grant);
    end
    @(negedge clk);
    checks++;
    if (ack !== '0 || q !== 8'hA5) begin
      fails++;
      $display("[TB] FAIL single_pulse: ack=%b q=%h, required 0000 a5", ack, q);
    end
    drain("single");
  endtask

  task automatic test_contention();
    int ack_cyc[$];
    logic [WIDTH-1:0] words [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    pulse_reset();
    wdata = {8'h44, 8'h33, 8'h22, 8'h11};
    for (int i = 0; i < 5; i++) sb_q.push_back('{id: IDW'(i % N), data: words[i % N]});
    req = 4'b1111;
    for (int c = 0; c < 20 && ack_cyc.size() < 5; c++) begin
      @(negedge clk);
      if (ack !== '0) ack_cyc.push_back(cycle);
    end
    req = '0;
    checks++;
    if (ack_cyc.size() != 5) begin
      fails++;
      $display("[TB] FAIL contention_count: %0d acks, required 5", ack_cyc.size());
    end else begin
      for (int i = 1; i < 5; i++) begin
        checks++;
        if (ack_cyc[i] - ack_cyc[i-1] != 2) begin
          fails++;
          $display("[TB] FAIL contention_spacing: gap %0d cycles, required 2", ack_cyc[i] - ack_cyc[i-1]);
        end
      end
    end
    drain("contention");
  endtask

  task automatic test_ack_mask();
    pulse_reset();
    wdata[1*WIDTH +: WIDTH] = 8'hB1;
    wdata[3*WIDTH +: WIDTH] = 8'hD3;
    req = 4'b0010;
    sb_q.push_back('{id: 2'd1, data: 8'hB1});
    sb_q.push_back('{id: 2'd3, data: 8'hD3});
    @(negedge clk);
    checks++;
    if (grant !== 4'b0010) begin
      fails++;
      $display("[TB] FAIL mask_first_grant: grant=%b, required 0010", grant);
    end
    req = 4'b1010;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (grant !== 4'b1000) begin
      fails++;
      $display("[TB] FAIL mask_next_grant: grant=%b, required 1000", grant);
    end
    req = '0;
    drain("mask");
  endtask

  task automatic test_committed();
    pulse_reset();
    wdata[0 +: WIDTH] = 8'h5A;
    req = 4'b0001;
    sb_q.push_back('{id: 2'd0, data: 8'h5A});
    @(negedge clk);
    req = '0;
    @(negedge clk);
    checks++;
    if (q !== 8'h5A || ack !== 4'b0001) begin
      fails++;
      $display("[TB] FAIL committed_write: q=%h ack=%b, required 5a 0001", q, ack);
    end
    drain("committed");
  endtask

  task automatic test_reset_mid();
    pulse_reset();
    wdata = {8'h44, 8'h77, 8'h22, 8'h3C};
    req = 4'b0001;
    sb_q.push_back('{id: 2'd0, data: 8'h3C});
    @(negedge clk);
    req = '0;
    drain("mid_preload");
    req = 4'b0100;
    @(negedge clk);
    checks++;
    if (grant !== 4'b0100 || busy !== 1'b1) begin
      fails++;
      $display("[TB] FAIL mid_grant: grant=%b busy=%b, required 0100 1", grant, busy);
    end
    reset = 1'b1;
    req   = '0;
    #1;
    checks++;
    if (q !== 8'h00 || grant !== '0 || busy !== 1'b0 || last_id !== '0) begin
      fails++;
      $display("[TB] FAIL mid_async_clear: q=%h grant=%b busy=%b last_id=%0d, required 00 0000 0 0",
               q, grant, busy, last_id);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    req = 4'b1001;
    sb_q.push_back('{id: 2'd0, data: 8'h3C});
    @(negedge clk);
    checks++;
    if (grant !== 4'b0001) begin
      fails++;
      $display("[TB] FAIL mid_ptr_cleared: grant=%b, required 0001", grant);
    end
    req = '0;
    drain("mid");
  endtask

  initial begin
    reset = 1'b1;
    req   = '0;
    wdata = '0;
    test_reset();
    test_single();
    test_contention();
    test_ack_mask();
    test_committed();
    test_reset_mid();
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
